// File: rtl/iomem_rr_arbiter.sv
// iomem_rr_arbiter: shares the single iomem slave port between NREQ requesters.
// Round-robin grant with one transaction in flight at a time. A watchdog forces
// completion (with TIMEOUT_RDATA and a sticky timeout_err) when the slave never
// acknowledges. Sequence per transaction: IDLE (arbitrate) -> ISSUE (m_valid
// held) -> DONE (one-cycle req_ready pulse) -> IDLE.
module iomem_rr_arbiter #(
    parameter int          NREQ           = 2,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF
) (
    input  logic                 CLKOUT,
    input  logic                 resetn,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_addr,
    input  logic [NREQ*32-1:0]   req_wdata,
    input  logic [NREQ*4-1:0]    req_wstrb,
    output logic [31:0]          req_rdata,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [31:0]          m_addr,
    output logic [31:0]          m_wdata,
    output logic [3:0]           m_wstrb,
    input  logic [31:0]          m_rdata,
    output logic [2:0]           grant_id,
    output logic                 timeout_err
);

    // Last watchdog count before the transaction is forced to complete.
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [2:0]  last_grant;
    logic [2:0]  pick;
    logic [2:0]  cand;
    logic        any_req;
    logic        start;
    logic        finish_ok;
    logic        finish_to;
    logic [15:0] wd_count;
    logic [7:0]  grant_onehot;

    // Requests padded out to the 8-entry maximum so a 3-bit index is always in range.
    logic [7:0]  valid8;
    logic [31:0] addr_arr  [8];
    logic [31:0] wdata_arr [8];
    logic [3:0]  wstrb_arr [8];

    for (genvar g = 0; g < 8; g++) begin : g_unpack
        if (g < NREQ) begin : g_used
            assign valid8[g]    = req_valid[g];
            assign addr_arr[g]  = req_addr[32*g +: 32];
            assign wdata_arr[g] = req_wdata[32*g +: 32];
            assign wstrb_arr[g] = req_wstrb[4*g +: 4];
        end else begin : g_pad
            assign valid8[g]    = 1'b0;
            assign addr_arr[g]  = '0;
            assign wdata_arr[g] = '0;
            assign wstrb_arr[g] = '0;
        end
    end

    // Round-robin search: first valid requester starting just after the last grant.
    always_comb begin
        pick    = last_grant;
        cand    = '0;
        any_req = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = 3'((int'(last_grant) + i) % NREQ);
            if (!any_req && valid8[cand]) begin
                any_req = 1'b1;
                pick    = cand;
            end
        end
    end

    // One-hot form of the current grant, used to steer the completion pulse.
    always_comb begin
        grant_onehot = 8'b1 << grant_id;
    end

    // Next-state and transaction control; m_ready beats a same-cycle watchdog expiry.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        finish_ok  = 1'b0;
        finish_to  = 1'b0;
        unique case (state)
            IDLE: begin
                if (any_req) begin
                    start      = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (m_ready) begin
                    finish_ok  = 1'b1;
                    state_next = DONE;
                end else if (wd_count == WD_LAST) begin
                    finish_to  = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                // The finishing requester still shows req_valid here, so skip arbitration.
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge CLKOUT) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Slave-side request, grant bookkeeping, watchdog and completion registers.
    always_ff @(posedge CLKOUT) begin
        if (!resetn) begin
            m_valid     <= 1'b0;
            m_addr      <= '0;
            m_wdata     <= '0;
            m_wstrb     <= '0;
            req_rdata   <= '0;
            req_ready   <= '0;
            grant_id    <= '0;
            timeout_err <= 1'b0;
            last_grant  <= 3'(NREQ - 1);
            wd_count    <= '0;
        end else begin
            req_ready <= '0;

            if (start) begin
                m_valid    <= 1'b1;
                m_addr     <= addr_arr[pick];
                m_wdata    <= wdata_arr[pick];
                m_wstrb    <= wstrb_arr[pick];
                grant_id   <= pick;
                last_grant <= pick;
                wd_count   <= '0;
            end

            if (state == ISSUE) begin
                wd_count <= wd_count + 16'd1;
            end

            if (finish_ok) begin
                m_valid   <= 1'b0;
                req_rdata <= m_rdata;
                req_ready <= grant_onehot[NREQ-1:0];
            end

            if (finish_to) begin
                m_valid     <= 1'b0;
                req_rdata   <= TIMEOUT_RDATA;
                req_ready   <= grant_onehot[NREQ-1:0];
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_iomem_rr_arbiter.sv
// Bench for iomem_rr_arbiter: requester/slave models plus a scoreboard of
// expected transactions compared against what the DUT issues and completes.
module tb_iomem_rr_arbiter;

    localparam int NREQ   = 2;
    localparam int TO_CYC = 4;

    logic                CLKOUT = 1'b0;
    logic                resetn;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*32-1:0]  req_addr;
    logic [NREQ*32-1:0]  req_wdata;
    logic [NREQ*4-1:0]   req_wstrb;
    logic [31:0]         req_rdata;
    logic                m_valid;
    logic                m_ready;
    logic [31:0]         m_addr;
    logic [31:0]         m_wdata;
    logic [3:0]          m_wstrb;
    logic [31:0]         m_rdata;
    logic [2:0]          grant_id;
    logic                timeout_err;

    always #5 CLKOUT = ~CLKOUT;

    iomem_rr_arbiter #(
        .NREQ(NREQ),
        .TIMEOUT_CYCLES(TO_CYC),
        .TIMEOUT_RDATA(32'hDEAD_BEEF)
    ) dut (
        .CLKOUT(CLKOUT), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .req_rdata(req_rdata),
        .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb), .m_rdata(m_rdata),
        .grant_id(grant_id), .timeout_err(timeout_err)
    );

    typedef struct {
        int          id;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        int          len;
        int          cyc;
    } txn_t;

    txn_t cmd0[$];
    txn_t cmd1[$];
    txn_t exp_q[$];
    txn_t iss_q[$];
    txn_t done_q[$];

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          mv_len = 0;
    int          scnt  = 0;
    logic        mv_prev = 1'b0;
    bit          slave_en = 1'b1;
    int          slave_delay = 0;
    logic [31:0] slave_rdata = '0;

    function automatic txn_t mk(input int id, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] wstrb, input logic [31:0] rdata);
        txn_t t;
        t.id = id; t.addr = addr; t.wdata = wdata; t.wstrb = wstrb; t.rdata = rdata;
        t.len = 0; t.cyc = 0;
        return t;
    endfunction

    // Requester, slave and monitor models, all evaluated on the falling edge.
    initial begin : bfm
        txn_t t;
        forever begin
            @(negedge CLKOUT);
            cyc++;
            if (m_valid && !mv_prev) begin
                t = mk(int'(grant_id), m_addr, m_wdata, m_wstrb, 32'h0);
                t.cyc = cyc;
                iss_q.push_back(t);
            end
            if (!resetn) mv_len = 0;
            else if (m_valid) mv_len++;
            if (req_ready != '0) begin
                t = mk(req_ready[1] ? 1 : 0, 32'h0, 32'h0, 4'h0, req_rdata);
                t.len = mv_len;
                t.cyc = cyc;
                done_q.push_back(t);
                mv_len = 0;
                total++;
                if ($countones(req_ready) != 1) begin
                    bad++;
                    $display("FAIL ready_onehot got=%b want=one bit set", req_ready);
                end
            end
            mv_prev = m_valid;
            if (!resetn || !m_valid || m_ready) begin
                m_ready = 1'b0;
                scnt    = 0;
            end else begin
                if (slave_en && scnt == slave_delay) m_ready = 1'b1;
                scnt++;
            end
            m_rdata = m_ready ? slave_rdata : 32'hFFFF_0000;
            if (req_ready[0] && cmd0.size() > 0) cmd0.delete(0);
            if (req_ready[1] && cmd1.size() > 0) cmd1.delete(0);
            if (cmd0.size() > 0) begin
                req_valid[0] = 1'b1; req_addr[31:0] = cmd0[0].addr;
                req_wdata[31:0] = cmd0[0].wdata; req_wstrb[3:0] = cmd0[0].wstrb;
            end else begin
                req_valid[0] = 1'b0;
            end
            if (cmd1.size() > 0) begin
                req_valid[1] = 1'b1; req_addr[63:32] = cmd1[0].addr;
                req_wdata[63:32] = cmd1[0].wdata; req_wstrb[7:4] = cmd1[0].wstrb;
            end else begin
                req_valid[1] = 1'b0;
            end
        end
    end

    task automatic wait_done(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge CLKOUT);
            if (done_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic reset_dut(input int cycles);
        resetn = 1'b0;
        cmd0.delete(); cmd1.delete(); exp_q.delete();
        repeat (cycles) @(negedge CLKOUT);
        iss_q.delete(); done_q.delete();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge CLKOUT);
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid got=%b want=0", m_valid); end
        total++; if (req_ready !== '0) begin bad++; $display("FAIL reset_req_ready got=%b want=0", req_ready); end
        total++; if ({m_addr, m_wdata, m_wstrb} !== 68'h0) begin bad++; $display("FAIL reset_m_bus got=%h/%h/%h want=0", m_addr, m_wdata, m_wstrb); end
        total++; if (req_rdata !== 32'h0) begin bad++; $display("FAIL reset_req_rdata got=%h want=0", req_rdata); end
        total++; if (grant_id !== 3'd0) begin bad++; $display("FAIL reset_grant_id got=%0d want=0", grant_id); end
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL reset_timeout_err got=%b want=0", timeout_err); end
        iss_q.delete(); done_q.delete();
        resetn = 1'b1;
        @(negedge CLKOUT);
    endtask

    task automatic test_single_write();
        txn_t e, i, d;
        bit ok;
        slave_en = 1'b1; slave_delay = 2; slave_rdata = 32'h0000_0000;
        e = mk(0, 32'h0300_0000, 32'h0000_A5A5, 4'b0011, 32'h0000_0000);
        exp_q.push_back(e); cmd0.push_back(e);
        wait_done(1, 50, ok);
        repeat (4) @(negedge CLKOUT);
        total++; if (!ok || done_q.size() != 1) begin bad++; $display("FAIL single_write_pulses got=%0d want=1", done_q.size()); end
        if (ok) begin
            e = exp_q.pop_front(); i = iss_q.pop_front(); d = done_q.pop_front();
            total++; if (i.addr !== e.addr || i.wdata !== e.wdata) begin bad++; $display("FAIL single_write_bus got=%h/%h want=%h/%h", i.addr, i.wdata, e.addr, e.wdata); end
            total++; if (i.wstrb !== e.wstrb) begin bad++; $display("FAIL single_write_wstrb got=%b want=%b", i.wstrb, e.wstrb); end
            total++; if (d.id !== 0 || i.id !== 0) begin bad++; $display("FAIL single_write_id got=%0d/%0d want=0", i.id, d.id); end
            total++; if (d.len !== 3 || d.cyc - i.cyc !== 3) begin bad++; $display("FAIL single_write_latency got=%0d/%0d want=3", d.len, d.cyc - i.cyc); end
        end
        iss_q.delete(); done_q.delete();
    endtask

    task automatic test_contention();
        txn_t e, i, d;
        bit ok;
        int prev_done;
        reset_dut(2);
        slave_en = 1'b1; slave_delay = 0; slave_rdata = 32'h1111_2222;
        e = mk(0, 32'h0300_0010, 32'hA000_0001, 4'hF, 32'h1111_2222); exp_q.push_back(e); cmd0.push_back(e);
        e = mk(1, 32'h0300_0014, 32'hB000_0001, 4'hF, 32'h1111_2222); exp_q.push_back(e); cmd1.push_back(e);
        e = mk(0, 32'h0300_0018, 32'hA000_0002, 4'hF, 32'h1111_2222); exp_q.push_back(e); cmd0.push_back(e);
        e = mk(1, 32'h0300_001C, 32'hB000_0002, 4'hF, 32'h1111_2222); exp_q.push_back(e); cmd1.push_back(e);
        wait_done(4, 100, ok);
        total++; if (!ok) begin bad++; $display("FAIL contention_count got=%0d want=4", done_q.size()); end
        prev_done = 0;
        if (ok) begin
            for (int k = 0; k < 4; k++) begin
                e = exp_q.pop_front(); i = iss_q.pop_front(); d = done_q.pop_front();
                total++; if (i.id !== e.id || d.id !== e.id) begin bad++; $display("FAIL contention_grant_%0d got=%0d/%0d want=%0d", k, i.id, d.id, e.id); end
                total++; if (i.addr !== e.addr || d.rdata !== e.rdata) begin bad++; $display("FAIL contention_data_%0d got=%h/%h want=%h/%h", k, i.addr, d.rdata, e.addr, e.rdata); end
                if (k > 0) begin
                    total++; if (i.cyc - prev_done !== 2) begin bad++; $display("FAIL contention_gap_%0d got=%0d want=2", k, i.cyc - prev_done); end
                end
                prev_done = d.cyc;
            end
        end
        iss_q.delete(); done_q.delete();
    endtask

    task automatic test_read();
        txn_t e, i, d;
        bit ok;
        slave_en = 1'b1; slave_delay = 1; slave_rdata = 32'h1234_5678;
        e = mk(1, 32'h0300_0000, 32'h0, 4'b0000, 32'h1234_5678);
        exp_q.push_back(e); cmd1.push_back(e);
        wait_done(1, 50, ok);
        total++; if (!ok) begin bad++; $display("FAIL read_done got=%0d want=1", done_q.size()); end
        if (ok) begin
            e = exp_q.pop_front(); i = iss_q.pop_front(); d = done_q.pop_front();
            total++; if (i.id !== 1 || d.id !== 1) begin bad++; $display("FAIL read_id got=%0d/%0d want=1", i.id, d.id); end
            total++; if (i.wstrb !== 4'b0000) begin bad++; $display("FAIL read_wstrb got=%b want=0000", i.wstrb); end
            total++; if (d.rdata !== e.rdata) begin bad++; $display("FAIL read_rdata got=%h want=%h", d.rdata, e.rdata); end
        end
        repeat (2) @(negedge CLKOUT);
        iss_q.delete(); done_q.delete();
    endtask

    task automatic test_timeout();
        txn_t e, d;
        bit ok;
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL timeout_err_before got=%b want=0", timeout_err); end
        slave_en = 1'b0;
        e = mk(0, 32'h0300_0004, 32'h0000_0001, 4'hF, 32'hDEAD_BEEF);
        exp_q.push_back(e); cmd0.push_back(e);
        wait_done(1, 50, ok);
        total++; if (!ok) begin bad++; $display("FAIL timeout_done got=%0d want=1", done_q.size()); end
        if (ok) begin
            e = exp_q.pop_front(); d = done_q.pop_front();
            total++; if (d.len !== TO_CYC) begin bad++; $display("FAIL timeout_len got=%0d want=%0d", d.len, TO_CYC); end
            total++; if (d.rdata !== e.rdata || d.id !== 0) begin bad++; $display("FAIL timeout_rdata got=%h/%0d want=%h/0", d.rdata, d.id, e.rdata); end
        end
        total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL timeout_err_set got=%b want=1", timeout_err); end
        repeat (2) @(negedge CLKOUT);
        slave_en = 1'b1; slave_delay = 1; slave_rdata = 32'hCAFE_0001;
        e = mk(1, 32'h0300_0008, 32'h0000_0002, 4'hF, 32'hCAFE_0001);
        exp_q.push_back(e); cmd1.push_back(e);
        wait_done(1, 50, ok);
        total++; if (!ok) begin bad++; $display("FAIL timeout_good_done got=%0d want=1", done_q.size()); end
        if (ok) begin
            e = exp_q.pop_front(); d = done_q.pop_front();
            total++; if (d.rdata !== e.rdata) begin bad++; $display("FAIL timeout_good_rdata got=%h want=%h", d.rdata, e.rdata); end
        end
        total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL timeout_err_sticky got=%b want=1", timeout_err); end
        repeat (2) @(negedge CLKOUT);
        iss_q.delete(); done_q.delete();
    endtask

    task automatic test_race();
        txn_t e, d;
        bit ok;
        reset_dut(2);
        slave_en = 1'b1; slave_delay = TO_CYC - 1; slave_rdata = 32'h5A5A_0003;
        e = mk(1, 32'h0300_0008, 32'h0, 4'b0000, 32'h5A5A_0003);
        exp_q.push_back(e); cmd1.push_back(e);
        wait_done(1, 50, ok);
        total++; if (!ok) begin bad++; $display("FAIL race_done got=%0d want=1", done_q.size()); end
        if (ok) begin
            e = exp_q.pop_front(); d = done_q.pop_front();
            total++; if (d.len !== TO_CYC) begin bad++; $display("FAIL race_len got=%0d want=%0d", d.len, TO_CYC); end
            total++; if (d.rdata !== e.rdata) begin bad++; $display("FAIL race_rdata got=%h want=%h", d.rdata, e.rdata); end
        end
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL race_timeout_err got=%b want=0", timeout_err); end
        repeat (2) @(negedge CLKOUT);
        iss_q.delete(); done_q.delete();
    endtask

    task automatic test_reset_mid();
        txn_t e0, e1, e, i, d;
        bit ok;
        bit seen;
        slave_en = 1'b0;
        e0 = mk(0, 32'h0300_0020, 32'h0000_0C0C, 4'b1100, 32'h7777_0000);
        e1 = mk(1, 32'h0300_0024, 32'h0000_0D0D, 4'b0001, 32'h7777_0000);
        cmd0.push_back(e0);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLKOUT);
            if (iss_q.size() > 0) begin
                seen = 1'b1;
                break;
            end
        end
        total++; if (!seen) begin bad++; $display("FAIL reset_mid_issue got=0 want=1"); end
        cmd1.push_back(e1);
        resetn = 1'b0;
        @(negedge CLKOUT);
        total++; if (m_valid !== 1'b0 || req_ready !== '0) begin bad++; $display("FAIL reset_mid_outputs got=%b/%b want=0/00", m_valid, req_ready); end
        total++; if (done_q.size() != 0) begin bad++; $display("FAIL reset_mid_pulse got=%0d want=0", done_q.size()); end
        iss_q.delete(); done_q.delete();
        slave_en = 1'b1; slave_delay = 0; slave_rdata = 32'h7777_0000;
        exp_q.push_back(e0); exp_q.push_back(e1);
        resetn = 1'b1;
        wait_done(2, 60, ok);
        total++; if (!ok) begin bad++; $display("FAIL reset_mid_done got=%0d want=2", done_q.size()); end
        if (ok) begin
            for (int k = 0; k < 2; k++) begin
                e = exp_q.pop_front(); i = iss_q.pop_front(); d = done_q.pop_front();
                total++; if (i.id !== e.id || d.id !== e.id || i.addr !== e.addr) begin bad++; $display("FAIL reset_mid_order_%0d got=%0d/%0d/%h want=%0d/%h", k, i.id, d.id, i.addr, e.id, e.addr); end
            end
        end
    endtask

    initial begin
        resetn    = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        m_ready   = 1'b0;
        m_rdata   = '0;
        test_reset();
        test_single_write();
        test_contention();
        test_read();
        test_timeout();
        test_race();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "bench time limit reached");
    end

endmodule
